// File: rtl/tdm_deser4_if.sv
`default_nettype none
// ============================================================================
// Module      : tdm_deser4_if
// Description : Serial input and per-channel parallel output bundle of the
//               four-channel TDM deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdm_deser4_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             din;
    logic             sync;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] ch_data0;
    logic [WIDTH-1:0] ch_data1;
    logic [WIDTH-1:0] ch_data2;
    logic [WIDTH-1:0] ch_data3;
    logic [3:0]       ch_valid;
    logic             locked;
    logic             frame_err;

    modport master (
        output en, din, sync,
        input  s1, s0, ch_data0, ch_data1, ch_data2, ch_data3,
        input  ch_valid, locked, frame_err
    );

    modport slave (
        input  en, din, sync,
        output s1, s0, ch_data0, ch_data1, ch_data2, ch_data3,
        output ch_valid, locked, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/tdm_deser4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_deser4
// Description : Four-channel TDM deserializer with HUNT/RUN frame alignment
//               on a sync marker; per-channel words with one-clk valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_deser4 #(
    parameter int WIDTH = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    tdm_deser4_if.slave  bus
);
    localparam int       c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [0:0] c_HUNT = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    logic [0:0]         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [1:0]         r_ch_cnt, w_ch_cnt_nxt;
    logic [WIDTH-1:0]   r_shift, w_shift_nxt, w_shift_in;
    logic [WIDTH-1:0]   r_ch_data [4];
    logic [WIDTH-1:0]   w_ch_data_nxt [4];
    logic [3:0]         r_ch_valid, w_ch_valid_nxt;
    logic               r_frame_err, w_frame_err_nxt;
    logic               w_at_expected;
    logic               w_last_bit;

    assign w_at_expected = (r_bit_cnt == '0) && (r_ch_cnt == 2'd0);
    assign w_last_bit    = (r_bit_cnt == c_CNT_W'(WIDTH - 1));
    assign w_shift_in    = {r_shift[WIDTH-2:0], bus.din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.en) begin
            case (r_state)
                c_HUNT:  if (bus.sync) w_state_nxt = c_RUN;
                c_RUN:   if (w_at_expected && !bus.sync) w_state_nxt = c_HUNT;
                default: w_state_nxt = c_HUNT;
            endcase
        end
    end

    // Next values for counters, shifter and registered outputs.
    always_comb begin
        w_bit_cnt_nxt   = r_bit_cnt;
        w_ch_cnt_nxt    = r_ch_cnt;
        w_shift_nxt     = r_shift;
        w_ch_data_nxt   = r_ch_data;
        w_ch_valid_nxt  = 4'b0000;
        w_frame_err_nxt = 1'b0;
        if (bus.en) begin
            case (r_state)
                c_HUNT: begin
                    if (bus.sync) begin
                        w_shift_nxt   = {{(WIDTH-1){1'b0}}, bus.din};
                        w_bit_cnt_nxt = c_CNT_W'(1);
                        w_ch_cnt_nxt  = 2'd0;
                    end
                end
                c_RUN: begin
                    if (w_at_expected && !bus.sync) begin
                        w_frame_err_nxt = 1'b1;
                        w_bit_cnt_nxt   = '0;
                        w_ch_cnt_nxt    = 2'd0;
                    end else if (!w_at_expected && bus.sync) begin
                        // Resync outranks slot completion: partial word is dropped.
                        w_frame_err_nxt = 1'b1;
                        w_shift_nxt     = {{(WIDTH-1){1'b0}}, bus.din};
                        w_bit_cnt_nxt   = c_CNT_W'(1);
                        w_ch_cnt_nxt    = 2'd0;
                    end else begin
                        w_shift_nxt = w_shift_in;
                        if (w_last_bit) begin
                            w_ch_data_nxt[r_ch_cnt] = w_shift_in;
                            w_ch_valid_nxt          = 4'b0001 << r_ch_cnt;
                            w_bit_cnt_nxt           = '0;
                            w_ch_cnt_nxt            = r_ch_cnt + 2'd1;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_bit_cnt_nxt = '0;
                    w_ch_cnt_nxt  = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= '0;
            r_ch_cnt    <= 2'd0;
            r_shift     <= '0;
            r_ch_data   <= '{default: '0};
            r_ch_valid  <= 4'b0000;
            r_frame_err <= 1'b0;
        end else begin
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_ch_cnt    <= w_ch_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_ch_data   <= w_ch_data_nxt;
            r_ch_valid  <= w_ch_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Channel counter is forced to 0 on HUNT entry, so it doubles as the select.
    assign bus.s1        = r_ch_cnt[1];
    assign bus.s0        = r_ch_cnt[0];
    assign bus.ch_data0  = r_ch_data[0];
    assign bus.ch_data1  = r_ch_data[1];
    assign bus.ch_data2  = r_ch_data[2];
    assign bus.ch_data3  = r_ch_data[3];
    assign bus.ch_valid  = r_ch_valid;
    assign bus.locked    = (r_state == c_RUN);
    assign bus.frame_err = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_tdm_deser4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_deser4
// Description : Scoreboard bench for tdm_deser4 with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_deser4;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdm_deser4_if #(.WIDTH(WIDTH)) bus ();
    tdm_deser4 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        int               ch;
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    exp_t vq[$];
    int   eq[$];
    int   cyc = 0;
    int   last_cyc = 0;
    int   gap = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [WIDTH-1:0] get_data(int ch);
        case (ch)
            0:       return bus.ch_data0;
            1:       return bus.ch_data1;
            2:       return bus.ch_data2;
            default: return bus.ch_data3;
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    exp_t m_e;
    int   m_f;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            while (vq.size() > 0 && vq[0].cyc < cyc) begin
                m_e = vq.pop_front();
                chk("missing_valid", cyc, m_e.cyc);
            end
            while (eq.size() > 0 && eq[0] < cyc) begin
                m_f = eq.pop_front();
                chk("missing_frame_err", cyc, m_f);
            end
            if (bus.ch_valid != 4'b0000) begin
                if (vq.size() == 0) begin
                    chk("unexpected_valid", bus.ch_valid, 0);
                end else begin
                    m_e = vq.pop_front();
                    chk("valid_cycle", cyc, m_e.cyc);
                    chk("valid_onehot", bus.ch_valid, 4'b0001 << m_e.ch);
                    chk("valid_data", get_data(m_e.ch), m_e.data);
                end
            end
            if (bus.frame_err) begin
                if (eq.size() == 0) begin
                    chk("unexpected_frame_err", bus.frame_err, 0);
                end else begin
                    m_f = eq.pop_front();
                    chk("frame_err_cycle", cyc, m_f);
                end
            end
        end
    end

    // en=0 gap cycles carry junk on din/sync to prove qualification by en.
    task automatic send_bit(input logic d, input logic s);
        repeat (gap) begin
            @(negedge clk);
            bus.en = 1'b0; bus.din = ~d; bus.sync = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        bus.en = 1'b1; bus.din = d; bus.sync = s;
        @(posedge clk);
        #1;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.en = 1'b0; bus.din = 1'b0; bus.sync = 1'b0;
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic first_sync, input int ch);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], first_sync && (i == WIDTH - 1));
        if (ch >= 0) vq.push_back('{ch, w, last_cyc});
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w0, w1, w2, w3);
        logic [WIDTH-1:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int c = 0; c < 4; c++) begin
            send_word(w[c], c == 0, c);
            chk("select_step", {bus.s1, bus.s0}, (c + 1) % 4);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] wd;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.din = 1'b0; bus.sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {bus.s1, bus.s0, bus.locked, bus.frame_err, bus.ch_valid,
                            bus.ch_data0, bus.ch_data1, bus.ch_data2, bus.ch_data3}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Lock, then assert reset asynchronously mid-frame with en toggling.
        gap = 1;
        send_bit(1'b1, 1'b1);
        chk("lock_after_sync", bus.locked, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {bus.s1, bus.s0, bus.locked, bus.frame_err, bus.ch_valid}, 0);
        repeat (3) begin
            @(negedge clk) bus.en = ~bus.en;
        end
        idle(1);
        @(negedge clk) rst_n = 1'b1;
        gap = 0;
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
        chk("hunt_locked_low", bus.locked, 0);
        chk("hunt_select_00", {bus.s1, bus.s0}, 0);
        idle(2);

        // Clean frame, then the same frame with en every third clk.
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
        chk("clean_ch_data0", bus.ch_data0, 8'hA5);
        chk("clean_ch_data1", bus.ch_data1, 8'h3C);
        chk("clean_ch_data2", bus.ch_data2, 8'hFF);
        chk("clean_ch_data3", bus.ch_data3, 8'h01);
        gap = 2;
        send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01);
        gap = 0;

        // Missed marker on frame 2, then relock.
        wd = 8'h5A;
        send_bit(wd[7], 1'b0);
        eq.push_back(last_cyc);
        chk("missed_locked_drop", bus.locked, 0);
        for (int i = 6; i >= 0; i--) send_bit(wd[i], 1'b0);
        for (int c = 1; c < 4; c++) send_word(8'hC6, 1'b0, -1);
        chk("missed_still_hunt", bus.locked, 0);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44);

        // Early marker on bit 3 of the channel-2 slot.
        send_word(8'h55, 1'b1, 0);
        send_word(8'h66, 1'b0, 1);
        wd = 8'hE7;
        for (int i = 7; i >= 5; i--) send_bit(wd[i], 1'b0);
        send_bit(1'b1, 1'b1);
        eq.push_back(last_cyc);
        chk("early_select_00", {bus.s1, bus.s0}, 0);
        chk("early_locked", bus.locked, 1);
        wd = 8'hC3;
        for (int i = 6; i >= 0; i--) send_bit(wd[i], 1'b0);
        vq.push_back('{0, 8'hC3, last_cyc});
        chk("early_ch_data2_kept", bus.ch_data2, 8'h33);
        send_word(8'h77, 1'b0, 1);
        send_word(8'h88, 1'b0, 2);
        send_word(8'h99, 1'b0, 3);

        // Marker collides with the last bit of the channel-1 slot.
        send_word(8'h12, 1'b1, 0);
        wd = 8'hAB;
        for (int i = 7; i >= 1; i--) send_bit(wd[i], 1'b0);
        send_bit(1'b1, 1'b1);
        eq.push_back(last_cyc);
        chk("collision_no_valid", bus.ch_valid, 0);
        chk("collision_frame_err", bus.frame_err, 1);
        chk("collision_ch_data1_kept", bus.ch_data1, 8'h77);
        wd = 8'h96;
        for (int i = 6; i >= 0; i--) send_bit(wd[i], 1'b0);
        vq.push_back('{0, 8'h96, last_cyc});
        send_word(8'h21, 1'b0, 1);
        send_word(8'h42, 1'b0, 2);
        send_word(8'h84, 1'b0, 3);
        idle(6);

        chk("scoreboard_valid_drained", vq.size(), 0);
        chk("scoreboard_err_drained", eq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
